// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, SR/Cause field positions, exception codes,
// and the exception-level state type.
package cp0_pkg;

  localparam logic [4:0] EXC_NONE = 5'd31;
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_SYS  = 5'd8;
  localparam logic [4:0] EXC_BP   = 5'd9;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int SR_IM_HI     = 15;
  localparam int CAUSE_EXC_LO = 2;
  localparam int CAUSE_EXC_HI = 6;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_IP_HI  = 15;
  localparam int CAUSE_BD     = 31;

  typedef enum logic {
    ST_NORMAL  = 1'b0,
    ST_HANDLER = 1'b1
  } cp0_state_e;

endpackage

// File: rtl/cp0_req_logic.sv
// Zero-latency interrupt/exception request arbitration; interrupts outrank exceptions.
module cp0_req_logic
  import cp0_pkg::*;
(
  input  logic       i_reset,
  input  logic [5:0] i_hw_int,
  input  logic [5:0] i_im,
  input  logic       i_ie,
  input  logic       i_exl,
  input  logic [4:0] i_exc_code,
  output logic       o_int_req,
  output logic       o_req
);

  logic w_int_req;
  logic w_exc_req;

  assign w_int_req = (|(i_hw_int & i_im)) & i_ie & ~i_exl;
  assign w_exc_req = (i_exc_code != EXC_NONE) & ~i_exl;

  // Nothing is taken while reset is held, whatever the inputs show.
  assign o_int_req = w_int_req & ~i_reset;
  assign o_req     = (w_int_req | w_exc_req) & ~i_reset;

endmodule

// File: rtl/cp0_ctrl.sv
// MIPS-style CP0 subset: SR, Cause, EPC, PRId with exception entry, eret and mtc0/mfc0.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID = 32'h2023_0007
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [4:0]  addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  input  logic [31:0] vpc,
  input  logic        bd_in,
  input  logic [4:0]  exc_code_in,
  input  logic [5:0]  hw_int,
  input  logic        exl_clr,
  output logic        req,
  output logic [31:0] epc_out
);

  cp0_state_e  r_state;
  cp0_state_e  w_state_next;
  logic [5:0]  r_im;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip;
  logic [4:0]  r_exc;
  logic [31:0] r_epc;

  logic        w_exl;
  logic        w_int_req;
  logic        w_req;
  logic        w_wr_sr;
  logic        w_wr_epc;
  logic [31:0] w_epc_src;
  logic [31:0] w_epc_entry;
  logic [31:0] w_epc_write;

  assign w_exl       = (r_state == ST_HANDLER);
  assign w_wr_sr     = en & ~w_req & (addr == ADDR_SR);
  assign w_wr_epc    = en & ~w_req & (addr == ADDR_EPC);
  assign w_epc_src   = bd_in ? (vpc - 32'd4) : vpc;
  assign w_epc_entry = w_epc_src & 32'hFFFF_FFFC;
  assign w_epc_write = data_in & 32'hFFFF_FFFC;

  cp0_req_logic u_req (
    .i_reset    (reset),
    .i_hw_int   (hw_int),
    .i_im       (r_im),
    .i_ie       (r_ie),
    .i_exl      (w_exl),
    .i_exc_code (exc_code_in),
    .o_int_req  (w_int_req),
    .o_req      (w_req)
  );

  // Exception-level state: entry beats eret, eret beats an mtc0 to SR.EXL.
  always_comb begin
    w_state_next = r_state;
    if (w_req) begin
      w_state_next = ST_HANDLER;
    end else if (exl_clr) begin
      w_state_next = ST_NORMAL;
    end else if (w_wr_sr) begin
      w_state_next = data_in[SR_EXL] ? ST_HANDLER : ST_NORMAL;
    end else begin
      w_state_next = r_state;
    end
  end

  // Exception-level state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_NORMAL;
    end else begin
      r_state <= w_state_next;
    end
  end

  // SR/Cause/EPC register file.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_im  <= 6'd0;
      r_ie  <= 1'b0;
      r_bd  <= 1'b0;
      r_ip  <= 6'd0;
      r_exc <= 5'd0;
      r_epc <= 32'd0;
    end else begin
      r_ip <= hw_int;
      if (w_req) begin
        r_exc <= w_int_req ? EXC_INT : exc_code_in;
        r_bd  <= bd_in;
        r_epc <= w_epc_entry;
      end else begin
        if (w_wr_sr) begin
          r_im <= data_in[SR_IM_HI:SR_IM_LO];
          r_ie <= data_in[SR_IE];
        end
        if (w_wr_epc) begin
          r_epc <= w_epc_write;
        end
      end
    end
  end

  // mfc0 read mux on pre-edge register values.
  always_comb begin
    data_out = 32'd0;
    case (addr)
      ADDR_SR:    data_out = {16'd0, r_im, 8'd0, w_exl, r_ie};
      ADDR_CAUSE: data_out = {r_bd, 15'd0, r_ip, 3'd0, r_exc, 2'd0};
      ADDR_EPC:   data_out = r_epc;
      ADDR_PRID:  data_out = PRID;
      default:    data_out = 32'd0;
    endcase
  end

  assign req     = w_req;
  assign epc_out = r_epc;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed scoreboard bench for cp0_ctrl: stimulus queues expectations, a negedge monitor checks them.
module tb_cp0_ctrl;

  logic        clk;
  logic        reset;
  logic        en;
  logic [4:0]  addr;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic [5:0]  hw_int;
  logic        exl_clr;
  logic        req;
  logic [31:0] epc_out;

  localparam logic [31:0] PRID_V = 32'h2023_0007;

  typedef struct {
    string       nm;
    logic [31:0] dout;
    logic        rq;
    logic [31:0] epc;
    logic        ce;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  cp0_ctrl #(.PRID(PRID_V)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .addr        (addr),
    .data_in     (data_in),
    .data_out    (data_out),
    .vpc         (vpc),
    .bd_in       (bd_in),
    .exc_code_in (exc_code_in),
    .hw_int      (hw_int),
    .exl_clr     (exl_clr),
    .req         (req),
    .epc_out     (epc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expectation per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if (req !== e.rq) begin
        n_err++;
        $display("FAIL %s req: got %0b expected %0b", e.nm, req, e.rq);
      end
      n_cmp++;
      if (data_out !== e.dout) begin
        n_err++;
        $display("FAIL %s data_out: got %h expected %h", e.nm, data_out, e.dout);
      end
      if (e.ce) begin
        n_cmp++;
        if (epc_out !== e.epc) begin
          n_err++;
          $display("FAIL %s epc_out: got %h expected %h", e.nm, epc_out, e.epc);
        end
      end
    end
  end

  task automatic cyc(input string nm, input logic rst, input logic e, input logic [4:0] a,
                     input logic [31:0] d, input logic [31:0] pc, input logic b,
                     input logic [4:0] ec, input logic [5:0] hw, input logic xc,
                     input logic xr, input logic [31:0] xd, input logic ce, input logic [31:0] xe);
    exp_t x;
    reset = rst; en = e; addr = a; data_in = d; vpc = pc; bd_in = b;
    exc_code_in = ec; hw_int = hw; exl_clr = xc;
    x.nm = nm; x.rq = xr; x.dout = xd; x.ce = ce; x.epc = xe;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; addr = 5'd0; data_in = 32'd0; vpc = 32'd0;
    bd_in = 1'b0; exc_code_in = 5'd31; hw_int = 6'd0; exl_clr = 1'b0;
    @(posedge clk);
    #1;
    //  name            rst   en    addr   data_in       vpc           bd    exc    hw         clr   req   data_out      ce    epc
    cyc("rst_prid",     1'b1, 1'b1, 5'd15, 32'hFFFF_FFFF, 32'h0000_1000, 1'b0, 5'd4,  6'h3F,     1'b1, 1'b0, PRID_V,        1'b0, 32'd0);
    cyc("rst_cause",    1'b1, 1'b0, 5'd13, 32'd0,         32'h0000_1000, 1'b0, 5'd4,  6'h3F,     1'b0, 1'b0, 32'd0,         1'b0, 32'd0);
    cyc("rst_epc",      1'b1, 1'b0, 5'd14, 32'd0,         32'h0000_1000, 1'b0, 5'd4,  6'h3F,     1'b0, 1'b0, 32'd0,         1'b1, 32'd0);
    cyc("rst_sr_wr",    1'b0, 1'b1, 5'd12, 32'h0000_0401, 32'h0000_1000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'd0,         1'b0, 32'd0);
    cyc("int_take",     1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_2000, 1'b0, 5'd31, 6'b000001, 1'b0, 1'b1, 32'h0000_0401, 1'b0, 32'd0);
    cyc("int_cause",    1'b0, 1'b0, 5'd13, 32'd0,         32'h0000_2100, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_0400, 1'b1, 32'h0000_2000);
    cyc("exl_block",    1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_2200, 1'b0, 5'd10, 6'h00,     1'b0, 1'b0, 32'h0000_0403, 1'b0, 32'd0);
    cyc("eret",         1'b0, 1'b0, 5'd13, 32'd0,         32'h0000_2200, 1'b0, 5'd10, 6'h00,     1'b1, 1'b0, 32'h0000_0000, 1'b1, 32'h0000_2000);
    cyc("exl_cleared",  1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_2300, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_0401, 1'b0, 32'd0);
    cyc("exc_bd",       1'b0, 1'b1, 5'd14, 32'h0000_3013, 32'h0000_3008, 1'b1, 5'd4,  6'h00,     1'b0, 1'b1, 32'h0000_2000, 1'b0, 32'd0);
    cyc("exc_cause",    1'b0, 1'b0, 5'd13, 32'd0,         32'h0000_3100, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h8000_0010, 1'b1, 32'h0000_3004);
    cyc("epc_wr",       1'b0, 1'b1, 5'd14, 32'h0000_1237, 32'h0000_3100, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_3004, 1'b0, 32'd0);
    cyc("epc_rd",       1'b0, 1'b0, 5'd14, 32'd0,         32'h0000_3100, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_1234, 1'b1, 32'h0000_1234);
    cyc("clr_vs_mtc0",  1'b0, 1'b1, 5'd12, 32'h0000_8003, 32'h0000_3100, 1'b0, 5'd31, 6'h00,     1'b1, 1'b0, 32'h0000_0403, 1'b0, 32'd0);
    cyc("sr_after",     1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_3100, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_8001, 1'b0, 32'd0);
    cyc("int_masked",   1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_3100, 1'b0, 5'd31, 6'b000001, 1'b0, 1'b0, 32'h0000_8001, 1'b0, 32'd0);
    cyc("int_prio",     1'b0, 1'b0, 5'd13, 32'd0,         32'h0000_0000, 1'b1, 5'd4,  6'b100000, 1'b0, 1'b1, 32'h8000_0410, 1'b0, 32'd0);
    cyc("wrap_cause",   1'b0, 1'b0, 5'd13, 32'd0,         32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h8000_8000, 1'b1, 32'hFFFF_FFFC);
    cyc("addr_other",   1'b0, 1'b0, 5'd5,  32'd0,         32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'd0,         1'b0, 32'd0);
    cyc("prid",         1'b0, 1'b0, 5'd15, 32'd0,         32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, PRID_V,        1'b0, 32'd0);
    cyc("mtc0_exl_clr", 1'b0, 1'b1, 5'd12, 32'h0000_8001, 32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_8003, 1'b0, 32'd0);
    cyc("normal_again", 1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'h0000_8001, 1'b0, 32'd0);
    cyc("rst_blocks",   1'b1, 1'b1, 5'd12, 32'h0000_0002, 32'h0000_4000, 1'b0, 5'd4,  6'h3F,     1'b0, 1'b0, 32'h0000_8001, 1'b0, 32'd0);
    cyc("rst_cleared",  1'b0, 1'b0, 5'd12, 32'd0,         32'h0000_4000, 1'b0, 5'd31, 6'h00,     1'b0, 1'b0, 32'd0,         1'b1, 32'd0);
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cp0_ctrl.md
CP0_CTRL -- requirements
Module: cp0_ctrl

Interface
REQ-001 SHALL have parameter PRID, default 32'h2023_0007, the constant returned for PRId reads.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port en  input  1  mtc0 write enable.
REQ-005 SHALL have port addr  input  5  CP0 register number for read and write.
REQ-006 SHALL have port data_in  input  32  mtc0 write data.
REQ-007 SHALL have port data_out  output  32  mfc0 read data, combinational from addr.
REQ-008 SHALL have port vpc  input  32  PC of the instruction at commit point.
REQ-009 SHALL have port bd_in  input  1  that instruction sits in a branch delay slot.
REQ-010 SHALL have port exc_code_in  input  5  pipeline exception code; 5'd31 = no exception.
REQ-011 SHALL have port hw_int  input  6  external interrupt lines, level-sensitive.
REQ-012 SHALL have port exl_clr  input  1  eret commit; clears EXL.
REQ-013 SHALL have port req  output  1  exception/interrupt taken this cycle; flushes pipeline, redirects PC.
REQ-014 SHALL have port epc_out  output  32  current EPC value.

Function
REQ-015 SHALL hold SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-016 SHALL hold Cause (13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-017 SHALL hold EPC (14) with 32 bits; PRId (15) SHALL read PRID; any other addr SHALL read 32'h0.
REQ-018 SHALL compute int_req = |(hw_int & SR.IM) & SR.IE & ~SR.EXL, combinationally.
REQ-019 SHALL compute exc_req = (exc_code_in != 5'd31) & ~SR.EXL; req = int_req | exc_req, same cycle, zero latency.
REQ-020 SHALL give interrupt priority over exception when both are asserted.
REQ-021 On req at clock edge: EXL<=1; ExcCode<=int_req ? 5'd0 : exc_code_in; BD<=bd_in; EPC<={(bd_in ? vpc-4 : vpc)[31:2],2'b00}.
REQ-022 SHALL update Cause.IP <= hw_int every cycle regardless of req, en, EXL.
REQ-023 When en & ~req: addr 12 SHALL write IM, EXL, IE from data_in; addr 14 SHALL write EPC with data_in[31:2],2'b00; other addresses ignored.
REQ-024 SHALL ignore en entirely in a cycle where req=1 (exception entry wins).
REQ-025 On exl_clr & ~req: EXL<=0, effective next cycle; exl_clr with en to SR same cycle: exl_clr SHALL win for EXL, mtc0 writes IM/IE.
REQ-026 SHALL behave as two-state machine: NORMAL (EXL=0) -> HANDLER on req; HANDLER -> NORMAL on exl_clr or mtc0 clearing EXL; req SHALL never assert in HANDLER.
REQ-027 data_out SHALL reflect pre-edge register values (no write-through bypass); epc_out SHALL equal EPC register.
REQ-028 vpc-4 SHALL wrap modulo 2^32.

Reset
REQ-029 On reset: SR=0, Cause=0, EPC=0; req=0 follows (IE=0, EXL=0, exc_code_in ignored only via IE? no: req SHALL be forced 0 during reset cycle).
REQ-030 Reset SHALL take priority over req, en, exl_clr in the same cycle; PRId unaffected.

Structure
REQ-031 Shared package SHALL hold EXC_NONE=5'd31, CP0 addresses 12/13/14/15, SR/Cause bit positions, exception code constants.
REQ-032 Request arbitration (REQ-018..020) SHALL be sub-module cp0_req_logic; register file stays in cp0_ctrl.

Verification
REQ-033 SR=32'h0000_0401, hw_int=6'b000001 -> req=1 same cycle; next cycle EXL=1, ExcCode=0, EPC=vpc.
REQ-034 exc_code_in=5'd4, bd_in=1, vpc=32'h0000_3008 -> req=1; EPC=32'h0000_3004, BD=1, ExcCode=4.
REQ-035 EXL=1, exc_code_in=5'd10 -> req=0, Cause/EPC unchanged; then exl_clr=1 -> EXL=0 next cycle.
REQ-036 en=1, addr=14, data_in=32'h0000_3013 with req=1 same cycle -> EPC takes vpc value, not 32'h0000_3010.
REQ-037 reset asserted with hw_int=6'h3F, exc_code_in=5'd4 -> req=0, SR/Cause/EPC read 0; addr 15 reads PRID.
